me_frame_scheduler: RTL and testbench



---
 rtl/me_frame_scheduler.sv | 207 ++++++++++++++++++++
 tb/tb_me_frame_scheduler.sv | 413 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/me_frame_scheduler.sv
// Motion-estimation frame scheduler.
// Walks the macroblocks of a frame in raster order, runs one four-phase
// handshake per macroblock with the ME core, queues each result in a
// 2-entry FIFO and keeps a saturating sum of the per-MB minimum SADs.
//
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   start, abort             frame start (IDLE only) / frame abort (busy only)
//   busy, frame_done         not-idle flag, one-cycle normal completion pulse
//   me_req, me_ack           four-phase handshake with the ME core
//   me_min_sad, me_min_mvec  core result, valid while me_ack=1
//   mb_x, mb_y               current macroblock coordinates
//   res_valid, res_ready     result FIFO head handshake
//   res_sad .. res_mb_y      result FIFO head entry
//   frame_sad                saturating frame SAD sum
module me_frame_scheduler #(
  parameter int unsigned MB_COLS     = 4,
  parameter int unsigned MB_ROWS     = 3,
  parameter int unsigned FRAME_SAD_W = 24
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  input  logic                   abort,
  output logic                   busy,
  output logic                   frame_done,
  output logic                   me_req,
  input  logic                   me_ack,
  input  logic [15:0]            me_min_sad,
  input  logic [9:0]             me_min_mvec,
  output logic [7:0]             mb_x,
  output logic [7:0]             mb_y,
  output logic                   res_valid,
  input  logic                   res_ready,
  output logic [15:0]            res_sad,
  output logic [9:0]             res_mvec,
  output logic [7:0]             res_mb_x,
  output logic [7:0]             res_mb_y,
  output logic [FRAME_SAD_W-1:0] frame_sad
);

  typedef enum logic [2:0] {StIdle, StIssue, StRelease, StHold, StFinish} state_e;

  localparam int unsigned            EntryW  = 42;
  localparam logic [7:0]             LastCol = 8'(MB_COLS - 1);
  localparam logic [7:0]             LastRow = 8'(MB_ROWS - 1);
  localparam logic [FRAME_SAD_W-1:0] SadMax  = '1;

  state_e                 state_q, state_d;
  logic                   abort_q, abort_d;
  logic [7:0]             mb_x_q, mb_x_d;
  logic [7:0]             mb_y_q, mb_y_d;
  logic [FRAME_SAD_W-1:0] frame_sad_q, frame_sad_d;
  logic                   done_q, done_d;

  logic [EntryW-1:0]      mem_q [2];
  logic [EntryW-1:0]      mem_d [2];
  logic                   wr_ptr_q, wr_ptr_d;
  logic                   rd_ptr_q, rd_ptr_d;
  logic [1:0]             count_q, count_d;

  logic                   push, pop, flush;
  logic                   abort_pend;
  logic                   last_mb;
  logic [FRAME_SAD_W:0]   sad_sum;
  logic [FRAME_SAD_W-1:0] sad_sat;

  // A same-cycle abort counts as pending, so HOLD/FINISH leave on the next edge.
  assign abort_pend = abort_q | abort;
  assign last_mb    = (mb_x_q == LastCol) && (mb_y_q == LastRow);
  assign push       = (state_q == StIssue) && me_ack;
  assign pop        = res_valid && res_ready;

  // One extra bit catches the carry; on overflow clamp instead of wrapping.
  assign sad_sum = {1'b0, frame_sad_q} + (FRAME_SAD_W + 1)'(me_min_sad);
  assign sad_sat = sad_sum[FRAME_SAD_W] ? SadMax : sad_sum[FRAME_SAD_W-1:0];

  always_comb begin
    state_d     = state_q;
    abort_d     = abort_q;
    mb_x_d      = mb_x_q;
    mb_y_d      = mb_y_q;
    frame_sad_d = frame_sad_q;
    done_d      = 1'b0;
    flush       = 1'b0;

    if (state_q != StIdle && abort) begin
      abort_d = 1'b1;
    end

    unique case (state_q)
      StIdle: begin
        abort_d = 1'b0;
        if (start) begin
          mb_x_d      = '0;
          mb_y_d      = '0;
          frame_sad_d = '0;
          state_d     = StIssue;
        end
      end
      StIssue: begin
        // An abort here still waits for the ack so the handshake closes cleanly.
        if (me_ack) begin
          frame_sad_d = sad_sat;
          state_d     = StRelease;
        end
      end
      StRelease: begin
        if (!me_ack) begin
          if (abort_pend) begin
            flush   = 1'b1;
            state_d = StIdle;
          end else if (last_mb) begin
            state_d = StFinish;
          end else begin
            if (mb_x_q == LastCol) begin
              mb_x_d = '0;
              mb_y_d = mb_y_q + 8'd1;
            end else begin
              mb_x_d = mb_x_q + 8'd1;
            end
            state_d = (count_q < 2'd2) ? StIssue : StHold;
          end
        end
      end
      StHold: begin
        if (abort_pend) begin
          flush   = 1'b1;
          state_d = StIdle;
        end else if (count_q < 2'd2) begin
          state_d = StIssue;
        end
      end
      StFinish: begin
        if (abort_pend) begin
          flush   = 1'b1;
          state_d = StIdle;
        end else if (count_q == 2'd0) begin
          done_d  = 1'b1;
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // Result FIFO; push and flush never coincide (push only in ISSUE).
  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush) begin
      wr_ptr_d = 1'b0;
      rd_ptr_d = 1'b0;
      count_d  = 2'd0;
    end else begin
      if (push) begin
        mem_d[wr_ptr_q] = {me_min_sad, me_min_mvec, mb_x_q, mb_y_q};
        wr_ptr_d        = ~wr_ptr_q;
      end
      if (pop) begin
        rd_ptr_d = ~rd_ptr_q;
      end
      count_d = count_q + {1'b0, push} - {1'b0, pop};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= StIdle;
      abort_q     <= 1'b0;
      mb_x_q      <= '0;
      mb_y_q      <= '0;
      frame_sad_q <= '0;
      done_q      <= 1'b0;
      wr_ptr_q    <= 1'b0;
      rd_ptr_q    <= 1'b0;
      count_q     <= 2'd0;
    end else begin
      state_q     <= state_d;
      abort_q     <= abort_d;
      mb_x_q      <= mb_x_d;
      mb_y_q      <= mb_y_d;
      frame_sad_q <= frame_sad_d;
      done_q      <= done_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
    end
  end

  // Payload storage needs no reset; res_valid qualifies it.
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

  assign busy       = (state_q != StIdle);
  assign me_req     = (state_q == StIssue);
  assign frame_done = done_q;
  assign mb_x       = mb_x_q;
  assign mb_y       = mb_y_q;
  assign frame_sad  = frame_sad_q;
  assign res_valid  = (count_q != 2'd0);
  assign {res_sad, res_mvec, res_mb_x, res_mb_y} = mem_q[rd_ptr_q];

endmodule

// File: tb/tb_me_frame_scheduler.sv
// Directed testbench for me_frame_scheduler.
// Instance dut: 2x2 frame, 24-bit frame SAD. Instance dut_sat: 5x4 frame, 20-bit frame SAD.
// Inputs are driven 1 time unit after a rising edge (core models at the falling edge);
// outputs are sampled on the falling edge.
module tb_me_frame_scheduler;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  // dut signals
  logic        rst, start, abort, me_ack, res_ready;
  logic [15:0] me_min_sad;
  logic [9:0]  me_min_mvec;
  logic        busy, frame_done, me_req, res_valid;
  logic [7:0]  mb_x, mb_y, res_mb_x, res_mb_y;
  logic [15:0] res_sad;
  logic [9:0]  res_mvec;
  logic [23:0] frame_sad;

  // dut_sat signals
  logic        start_b, me_ack_b;
  logic [15:0] me_min_sad_b;
  logic [9:0]  me_min_mvec_b;
  logic        busy_b, frame_done_b, me_req_b, res_valid_b;
  logic [7:0]  mb_x_b, mb_y_b, res_mb_x_b, res_mb_y_b;
  logic [15:0] res_sad_b;
  logic [9:0]  res_mvec_b;
  logic [19:0] frame_sad_b;

  me_frame_scheduler #(.MB_COLS(2), .MB_ROWS(2), .FRAME_SAD_W(24)) dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort), .busy(busy),
    .frame_done(frame_done), .me_req(me_req), .me_ack(me_ack),
    .me_min_sad(me_min_sad), .me_min_mvec(me_min_mvec), .mb_x(mb_x), .mb_y(mb_y),
    .res_valid(res_valid), .res_ready(res_ready), .res_sad(res_sad),
    .res_mvec(res_mvec), .res_mb_x(res_mb_x), .res_mb_y(res_mb_y),
    .frame_sad(frame_sad)
  );

  me_frame_scheduler #(.MB_COLS(5), .MB_ROWS(4), .FRAME_SAD_W(20)) dut_sat (
    .clk(clk), .rst(rst), .start(start_b), .abort(1'b0), .busy(busy_b),
    .frame_done(frame_done_b), .me_req(me_req_b), .me_ack(me_ack_b),
    .me_min_sad(me_min_sad_b), .me_min_mvec(me_min_mvec_b), .mb_x(mb_x_b),
    .mb_y(mb_y_b), .res_valid(res_valid_b), .res_ready(1'b1), .res_sad(res_sad_b),
    .res_mvec(res_mvec_b), .res_mb_x(res_mb_x_b), .res_mb_y(res_mb_y_b),
    .frame_sad(frame_sad_b)
  );

  // Core model for dut: acks on the 3rd falling edge with me_req high.
  logic [15:0] sad_tab [4];
  int core_idx = 0;
  int ack_cnt  = 0;
  initial begin
    int core_wait;
    core_wait   = 0;
    me_ack      = 1'b0;
    me_min_sad  = '0;
    me_min_mvec = '0;
    forever begin
      @(negedge clk);
      if (me_ack) begin
        if (!me_req) me_ack = 1'b0;
      end else if (me_req) begin
        core_wait++;
        if (core_wait == 3) begin
          core_wait   = 0;
          me_ack      = 1'b1;
          me_min_sad  = sad_tab[core_idx % 4];
          me_min_mvec = 10'(core_idx * 37 + 5);
          core_idx++;
          ack_cnt++;
        end
      end else begin
        core_wait = 0;
      end
    end
  end

  // Core model for dut_sat: every SAD is 0xFFFF.
  int ack_cnt_b = 0;
  initial begin
    me_ack_b      = 1'b0;
    me_min_sad_b  = 16'hFFFF;
    me_min_mvec_b = 10'h155;
    forever begin
      @(negedge clk);
      if (me_ack_b) begin
        if (!me_req_b) me_ack_b = 1'b0;
      end else if (me_req_b) begin
        me_ack_b = 1'b1;
        ack_cnt_b++;
      end
    end
  end

  // Monitors.
  logic [41:0] got [$];
  int done_cnt = 0, rise_cnt = 0;
  int pop_cnt_b = 0, done_cnt_b = 0, wrap_cnt_b = 0;
  initial begin
    logic        req_prev;
    logic [19:0] sad_prev_b;
    req_prev   = 1'b0;
    sad_prev_b = '0;
    forever begin
      @(negedge clk);
      if (res_valid && res_ready) got.push_back({res_sad, res_mvec, res_mb_x, res_mb_y});
      if (frame_done) done_cnt++;
      if (me_req && !req_prev) rise_cnt++;
      req_prev = me_req;
      if (res_valid_b) pop_cnt_b++;
      if (frame_done_b) done_cnt_b++;
      if (busy_b && (frame_sad_b < sad_prev_b)) wrap_cnt_b++;
      sad_prev_b = frame_sad_b;
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic pulse_start();
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
  endtask

  task automatic settle();
    repeat (3) @(negedge clk);
    #1;
  endtask

  task automatic wait_done(input string name, input int max);
    bit seen = 1'b0;
    for (int i = 0; i < max; i++) begin
      @(negedge clk);
      if (frame_done === 1'b1) begin
        seen = 1'b1;
        break;
      end
    end
    checks++;
    if (!seen) begin
      failures++;
      $display("FAIL %s_done: frame_done got 0 for %0d cycles, want a pulse", name, max);
    end else begin
      @(negedge clk);
      checks++;
      if (busy !== 1'b0) begin
        failures++;
        $display("FAIL %s_busy_after_done: got %b want 0", name, busy);
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; abort = 1'b0; res_ready = 1'b0; start_b = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks += 8;
    if (busy !== 1'b0) begin failures++; $display("FAIL rst_busy: got %b want 0", busy); end
    if (frame_done !== 1'b0) begin
      failures++; $display("FAIL rst_done: got %b want 0", frame_done);
    end
    if (me_req !== 1'b0) begin failures++; $display("FAIL rst_req: got %b want 0", me_req); end
    if (res_valid !== 1'b0) begin
      failures++; $display("FAIL rst_valid: got %b want 0", res_valid);
    end
    if (mb_x !== 8'd0) begin failures++; $display("FAIL rst_mb_x: got %0d want 0", mb_x); end
    if (mb_y !== 8'd0) begin failures++; $display("FAIL rst_mb_y: got %0d want 0", mb_y); end
    if (frame_sad !== 24'd0) begin
      failures++; $display("FAIL rst_frame_sad: got %0d want 0", frame_sad);
    end
    if (busy_b !== 1'b0) begin failures++; $display("FAIL rst_busy_b: got %b want 0", busy_b); end
    @(posedge clk); #1 rst = 1'b0;
  endtask

  task automatic test_nominal();
    logic [15:0] vals [4];
    logic [41:0] exp;
    int i0, g0, d0;
    vals = '{16'd100, 16'd50, 16'd70, 16'd20};
    i0 = core_idx; g0 = got.size(); d0 = done_cnt;
    for (int j = 0; j < 4; j++) sad_tab[(i0 + j) % 4] = vals[j];
    res_ready = 1'b1;
    pulse_start();
    @(negedge clk);
    checks++;
    if (me_req !== 1'b1) begin failures++; $display("FAIL nom_req_after_start: got %b want 1", me_req); end
    wait_done("nom", 400);
    settle();
    checks += 3;
    if (frame_sad !== 24'd240) begin
      failures++; $display("FAIL nom_frame_sad: got %0d want 240", frame_sad);
    end
    if (got.size() - g0 != 4) begin
      failures++; $display("FAIL nom_result_count: got %0d want 4", got.size() - g0);
    end
    if (done_cnt - d0 != 1) begin
      failures++; $display("FAIL nom_done_pulses: got %0d want 1", done_cnt - d0);
    end
    for (int j = 0; j < 4; j++) begin
      exp = {vals[j], 10'((i0 + j) * 37 + 5), 8'(j % 2), 8'(j / 2)};
      checks++;
      if (got[g0 + j] !== exp) begin
        failures++; $display("FAIL nom_result%0d: got %h want %h", j, got[g0 + j], exp);
      end
    end
  endtask

  task automatic test_backpressure();
    logic [15:0] vals [4];
    logic [41:0] exp;
    int i0, g0, a0, req_hi;
    bit seen;
    vals = '{16'd11, 16'd22, 16'd33, 16'd44};
    i0 = core_idx; g0 = got.size(); a0 = ack_cnt;
    for (int j = 0; j < 4; j++) sad_tab[(i0 + j) % 4] = vals[j];
    res_ready = 1'b0;
    pulse_start();
    seen = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (ack_cnt - a0 == 2) begin seen = 1'b1; break; end
    end
    checks++;
    if (!seen) begin failures++; $display("FAIL bp_two_acks: got %0d acks want 2", ack_cnt - a0); end
    req_hi = 0;
    repeat (10) begin
      @(negedge clk);
      if (me_req) req_hi++;
    end
    checks += 5;
    if (req_hi != 0) begin failures++; $display("FAIL bp_hold_req: got %0d high cycles want 0", req_hi); end
    if (busy !== 1'b1) begin failures++; $display("FAIL bp_hold_busy: got %b want 1", busy); end
    if (res_valid !== 1'b1) begin failures++; $display("FAIL bp_hold_valid: got %b want 1", res_valid); end
    if (mb_x !== 8'd0) begin failures++; $display("FAIL bp_hold_mb_x: got %0d want 0", mb_x); end
    if (mb_y !== 8'd1) begin failures++; $display("FAIL bp_hold_mb_y: got %0d want 1", mb_y); end
    @(posedge clk); #1 res_ready = 1'b1;
    @(posedge clk); #1 res_ready = 1'b0;
    @(negedge clk);
    checks++;
    if (me_req !== 1'b0) begin failures++; $display("FAIL bp_req_same_cycle: got %b want 0", me_req); end
    @(negedge clk);
    checks++;
    if (me_req !== 1'b1) begin failures++; $display("FAIL bp_req_rise: got %b want 1", me_req); end
    @(posedge clk); #1 res_ready = 1'b1;
    wait_done("bp", 400);
    settle();
    checks++;
    if (got.size() - g0 != 4) begin
      failures++; $display("FAIL bp_result_count: got %0d want 4", got.size() - g0);
    end
    for (int j = 0; j < 4; j++) begin
      exp = {vals[j], 10'((i0 + j) * 37 + 5), 8'(j % 2), 8'(j / 2)};
      checks++;
      if (got[g0 + j] !== exp) begin
        failures++; $display("FAIL bp_result%0d: got %h want %h", j, got[g0 + j], exp);
      end
    end
  endtask

  task automatic test_abort();
    int g0, d0, r0, a0;
    bit seen;
    g0 = got.size(); d0 = done_cnt; r0 = rise_cnt; a0 = ack_cnt;
    res_ready = 1'b1;
    pulse_start();
    seen = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (me_req && mb_x == 8'd1 && mb_y == 8'd0) begin seen = 1'b1; break; end
    end
    checks++;
    if (!seen) begin failures++; $display("FAIL ab_reach_mb10: got no ISSUE for MB (1,0)"); end
    @(posedge clk); #1 abort = 1'b1;
    @(posedge clk); #1 abort = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (!busy) begin seen = 1'b1; break; end
    end
    checks++;
    if (!seen) begin failures++; $display("FAIL ab_idle: busy got 1 want 0"); end
    repeat (10) @(negedge clk);
    #1;
    checks += 7;
    if (ack_cnt - a0 != 2) begin failures++; $display("FAIL ab_acks: got %0d want 2", ack_cnt - a0); end
    if (rise_cnt - r0 != 2) begin
      failures++; $display("FAIL ab_req_rises: got %0d want 2", rise_cnt - r0);
    end
    if (res_valid !== 1'b0) begin failures++; $display("FAIL ab_valid: got %b want 0", res_valid); end
    if (busy !== 1'b0) begin failures++; $display("FAIL ab_busy: got %b want 0", busy); end
    if (done_cnt != d0) begin failures++; $display("FAIL ab_done: got %0d pulses want 0", done_cnt - d0); end
    if (got.size() - g0 != 2) begin
      failures++; $display("FAIL ab_results: got %0d want 2", got.size() - g0);
    end
    if (got[g0 + 1][15:0] !== 16'h0100) begin
      failures++; $display("FAIL ab_last_coord: got %h want 0100", got[g0 + 1][15:0]);
    end
  endtask

  task automatic test_start_busy();
    int g0, d0, a0;
    bit seen, prev;
    g0 = got.size(); d0 = done_cnt; a0 = ack_cnt;
    res_ready = 1'b1;
    pulse_start();
    seen = 1'b0; prev = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (prev && !me_req && busy) begin seen = 1'b1; break; end
      prev = me_req;
    end
    checks++;
    if (!seen) begin failures++; $display("FAIL sb_reach_release: no RELEASE observed"); end
    start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    wait_done("sb", 400);
    settle();
    checks += 3;
    if (got.size() - g0 != 4) begin
      failures++; $display("FAIL sb_result_count: got %0d want 4", got.size() - g0);
    end
    if (ack_cnt - a0 != 4) begin failures++; $display("FAIL sb_acks: got %0d want 4", ack_cnt - a0); end
    if (done_cnt - d0 != 1) begin
      failures++; $display("FAIL sb_done_pulses: got %0d want 1", done_cnt - d0);
    end
    for (int j = 0; j < 4; j++) begin
      checks++;
      if (got[g0 + j][15:0] !== {8'(j % 2), 8'(j / 2)}) begin
        failures++;
        $display("FAIL sb_coord%0d: got %h want %h", j, got[g0 + j][15:0], {8'(j % 2), 8'(j / 2)});
      end
    end
  endtask

  task automatic test_reset_mid();
    int a0;
    bit seen;
    a0 = ack_cnt;
    res_ready = 1'b0;
    pulse_start();
    seen = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (me_req && mb_x == 8'd1 && ack_cnt - a0 == 1) begin seen = 1'b1; break; end
    end
    checks += 2;
    if (!seen) begin failures++; $display("FAIL rm_reach_mb10: no ISSUE for MB (1,0)"); end
    if (res_valid !== 1'b1) begin failures++; $display("FAIL rm_pending: got %b want 1", res_valid); end
    @(posedge clk); #1 rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    checks += 4;
    if (me_req !== 1'b0) begin failures++; $display("FAIL rm_req: got %b want 0", me_req); end
    if (busy !== 1'b0) begin failures++; $display("FAIL rm_busy: got %b want 0", busy); end
    if (res_valid !== 1'b0) begin failures++; $display("FAIL rm_valid: got %b want 0", res_valid); end
    if (frame_sad !== 24'd0) begin failures++; $display("FAIL rm_frame_sad: got %0d want 0", frame_sad); end
    res_ready = 1'b1;
    pulse_start();
    @(negedge clk);
    checks += 3;
    if (me_req !== 1'b1) begin failures++; $display("FAIL rm_restart_req: got %b want 1", me_req); end
    if (mb_x !== 8'd0) begin failures++; $display("FAIL rm_restart_x: got %0d want 0", mb_x); end
    if (mb_y !== 8'd0) begin failures++; $display("FAIL rm_restart_y: got %0d want 0", mb_y); end
    wait_done("rm", 400);
    settle();
  endtask

  task automatic test_saturation();
    int p0;
    bit seen;
    p0 = pop_cnt_b;
    @(posedge clk); #1 start_b = 1'b1;
    @(posedge clk); #1 start_b = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 1000; i++) begin
      @(negedge clk);
      if (frame_done_b) begin seen = 1'b1; break; end
    end
    checks++;
    if (!seen) begin failures++; $display("FAIL sat_done: frame_done never pulsed"); end
    settle();
    checks += 4;
    if (frame_sad_b !== 20'hFFFFF) begin
      failures++; $display("FAIL sat_frame_sad: got %h want fffff", frame_sad_b);
    end
    if (wrap_cnt_b != 0) begin failures++; $display("FAIL sat_wrap: got %0d decreases want 0", wrap_cnt_b); end
    if (pop_cnt_b - p0 != 20) begin
      failures++; $display("FAIL sat_results: got %0d want 20", pop_cnt_b - p0);
    end
    if (ack_cnt_b != 20) begin failures++; $display("FAIL sat_acks: got %0d want 20", ack_cnt_b); end
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; abort = 1'b0; res_ready = 1'b0; start_b = 1'b0;
    for (int j = 0; j < 4; j++) sad_tab[j] = 16'd1;
    test_reset();
    test_nominal();
    test_backpressure();
    test_abort();
    test_start_busy();
    test_reset_mid();
    test_saturation();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
